// File: rtl/ber_window_monitor.sv
// ber_window_monitor: session BER statistics with windowed error counts and four-phase snapshot port.
// Optional max-window tracking is enabled by defining BER_MONITOR_MAXWIN_EN.
module ber_window_monitor #(
    parameter int WINDOW_LOG2 = 20,
    parameter int SETTLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aligned,
    input  logic [6:0]  error_count,
    input  logic        start,
    input  logic        stop,
    input  logic        snap_req,
    output logic        snap_ack,
    output logic [1:0]  state,
    output logic [47:0] total_bits,
    output logic [31:0] total_errors,
    output logic [7:0]  lock_losses,
    output logic [23:0] win_errors,
    output logic        win_done,
    output logic [23:0] max_win_errors,
    output logic [47:0] snap_bits,
    output logic [31:0] snap_errors,
    output logic [7:0]  snap_losses
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LOCK = 2'd1, RUN = 2'd2, UNLOCKED = 2'd3} state_t;
    state_t cur, nxt;
    logic [7:0] settle_cnt;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [23:0] win_acc;
    logic [48:0] bits_sum;
    logic [32:0] errs_sum;
    logic [24:0] win_sum;
    logic [47:0] bits_sat;
    logic [31:0] errs_sat;
    logic [23:0] win_sat;
    logic clear, waiting, settled, count, lose, win_end;
    assign state = cur;
    // stop overrides start in every state, including IDLE
    assign clear = start && !stop;
    assign waiting = (cur == WAIT_LOCK) || (cur == UNLOCKED);
    assign settled = waiting && aligned && settle_cnt == 8'(SETTLE - 1);
    assign count = cur == RUN && !stop && !start && aligned;
    assign lose = cur == RUN && !stop && !start && !aligned;
    assign win_end = count && &win_cnt;
    assign bits_sum = {1'b0, total_bits} + 49'd64;
    assign errs_sum = {1'b0, total_errors} + 33'(error_count);
    assign win_sum = {1'b0, win_acc} + 25'(error_count);
    assign bits_sat = bits_sum[48] ? '1 : bits_sum[47:0];
    assign errs_sat = errs_sum[32] ? '1 : errs_sum[31:0];
    assign win_sat = win_sum[24] ? '1 : win_sum[23:0];
    always_ff @(posedge clk)
        cur <= reset ? IDLE : nxt;
    always_comb begin
        nxt = cur;
        if (stop)
            nxt = IDLE;
        else if (start)
            nxt = WAIT_LOCK;
        else if (settled)
            nxt = RUN;
        else if (lose)
            nxt = UNLOCKED;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_ack <= 1'b0;
            snap_bits <= '0;
            snap_errors <= '0;
            snap_losses <= '0;
            total_bits <= '0;
            total_errors <= '0;
            lock_losses <= '0;
            win_errors <= '0;
            win_done <= 1'b0;
            win_acc <= '0;
            win_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            win_done <= 1'b0;
            snap_ack <= snap_req;
            if (snap_req && !snap_ack) begin
                snap_bits <= total_bits;
                snap_errors <= total_errors;
                snap_losses <= lock_losses;
            end
            if (clear) begin
                total_bits <= '0;
                total_errors <= '0;
                lock_losses <= '0;
                win_errors <= '0;
                win_acc <= '0;
                win_cnt <= '0;
                settle_cnt <= '0;
            end else if (count) begin
                total_bits <= bits_sat;
                total_errors <= errs_sat;
                win_cnt <= win_cnt + WINDOW_LOG2'(1);
                win_acc <= win_end ? '0 : win_sat;
                if (win_end) begin
                    win_errors <= win_sat;
                    win_done <= 1'b1;
                end
            end else if (lose) begin
                lock_losses <= (lock_losses == 8'hff) ? lock_losses : lock_losses + 8'd1;
                win_acc <= '0;
                win_cnt <= '0;
            end
            if (!clear && waiting)
                settle_cnt <= (!aligned || settled) ? 8'd0 : settle_cnt + 8'd1;
        end
    end
`ifdef BER_MONITOR_MAXWIN_EN
    always_ff @(posedge clk)
        if (reset || clear)
            max_win_errors <= '0;
        else if (win_end && win_sat > max_win_errors)
            max_win_errors <= win_sat;
`else
    assign max_win_errors = '0;
`endif
endmodule

// File: tb/tb_ber_window_monitor.sv
// tb_ber_window_monitor: directed checks of session control, windows, lock loss, settle and snapshot.
module tb_ber_window_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic aligned = 1'b0;
    logic [6:0] error_count = '0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic snap_req = 1'b0;
    logic snap_ack, win_done;
    logic [1:0] state;
    logic [47:0] total_bits, snap_bits;
    logic [31:0] total_errors, snap_errors;
    logic [7:0] lock_losses, snap_losses;
    logic [23:0] win_errors, max_win_errors;
    int errors = 0;
    int checks = 0;
    ber_window_monitor #(.WINDOW_LOG2(4), .SETTLE(4)) dut (
        .clk(clk), .reset(reset), .aligned(aligned), .error_count(error_count),
        .start(start), .stop(stop), .snap_req(snap_req), .snap_ack(snap_ack),
        .state(state), .total_bits(total_bits), .total_errors(total_errors),
        .lock_losses(lock_losses), .win_errors(win_errors), .win_done(win_done),
        .max_win_errors(max_win_errors), .snap_bits(snap_bits),
        .snap_errors(snap_errors), .snap_losses(snap_losses)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    initial begin
        logic [23:0] max_exp;
`ifdef BER_MONITOR_MAXWIN_EN
        max_exp = 24'd48;
`else
        max_exp = 24'd0;
`endif
        tick(2);
        reset = 1'b0;
        check("rst_state", state, 0);
        check("rst_bits", total_bits, 0);
        check("rst_ack", snap_ack, 0);
        check("rst_win", win_errors, 0);
        // clean run
        start = 1'b1;
        tick(1);
        start = 1'b0;
        aligned = 1'b1;
        check("clean_wait", state, 1);
        tick(3);
        check("clean_wait3", state, 1);
        tick(1);
        check("clean_run", state, 2);
        check("clean_bits0", total_bits, 0);
        tick(15);
        check("clean_nodone", win_done, 0);
        check("clean_bits15", total_bits, 960);
        tick(1);
        check("clean_done", win_done, 1);
        check("clean_win", win_errors, 0);
        check("clean_bits16", total_bits, 1024);
        tick(1);
        check("clean_done_pulse", win_done, 0);
        // error accumulation, restarted from RUN
        start = 1'b1;
        error_count = 7'd3;
        tick(1);
        start = 1'b0;
        check("err_restart", state, 1);
        check("err_cleared", total_bits, 0);
        tick(4);
        check("err_run", state, 2);
        check("err_none_yet", total_errors, 0);
        tick(16);
        check("err_done1", win_done, 1);
        check("err_win1", win_errors, 48);
        check("err_total1", total_errors, 48);
        check("err_max", max_win_errors, max_exp);
        tick(16);
        check("err_done2", win_done, 1);
        check("err_total2", total_errors, 96);
        // lock loss after 10 RUN cycles
        tick(10);
        aligned = 1'b0;
        tick(1);
        check("ll_state", state, 3);
        check("ll_losses", lock_losses, 1);
        check("ll_total", total_errors, 126);
        check("ll_nodone", win_done, 0);
        tick(1);
        aligned = 1'b1;
        tick(3);
        check("ll_settling", state, 3);
        tick(1);
        check("ll_rerun", state, 2);
        tick(15);
        check("ll_nodone15", win_done, 0);
        tick(1);
        check("ll_done", win_done, 1);
        check("ll_win", win_errors, 48);
        check("ll_total2", total_errors, 174);
        // settle glitch 1,1,1,0,1,1,1,1
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        aligned = 1'b0;
        tick(1);
        check("gl_after0", state, 1);
        aligned = 1'b1;
        tick(3);
        check("gl_three", state, 1);
        tick(1);
        check("gl_run", state, 2);
        check("gl_losses", lock_losses, 0);
        // snapshot during RUN
        tick(5);
        check("sn_bits_pre", total_bits, 320);
        snap_req = 1'b1;
        tick(1);
        check("sn_ack", snap_ack, 1);
        check("sn_bits", snap_bits, 320);
        check("sn_errs", snap_errors, 15);
        check("sn_bits_live", total_bits, 384);
        tick(3);
        check("sn_hold_ack", snap_ack, 1);
        check("sn_hold_bits", snap_bits, 320);
        check("sn_live2", total_bits, 576);
        snap_req = 1'b0;
        tick(1);
        check("sn_ack_low", snap_ack, 0);
        check("sn_keep", snap_bits, 320);
        // start and stop together in RUN
        start = 1'b1;
        stop = 1'b1;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        check("cc_idle", state, 0);
        check("cc_bits", total_bits, 640);
        check("cc_errs", total_errors, 30);
        check("cc_max", max_win_errors, 0);
        tick(2);
        check("cc_idle_hold", total_bits, 640);
        // reset mid-handshake
        snap_req = 1'b1;
        tick(1);
        check("rh_ack", snap_ack, 1);
        check("rh_snap", snap_bits, 640);
        reset = 1'b1;
        tick(1);
        check("rh_ack0", snap_ack, 0);
        check("rh_snap0", snap_bits, 0);
        check("rh_bits0", total_bits, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ber_window_monitor.md
# ber_window_monitor

Downstream statistics stage for the 64-bit PRBS7 link checker. It consumes the checker's lock status (`aligned`) and per-word error-bit count, and runs a start/stop measurement session. During a session it accumulates checked-bit and error-bit totals, counts lock losses and reports per-window error counts. A four-phase request/acknowledge snapshot port gives slow-control logic a coherent copy of the totals.

## Interface
- `WINDOW_LOG2`, default 20: window length is 2^WINDOW_LOG2 RUN cycles.
- `SETTLE`, default 16: consecutive `aligned` cycles required before counting starts or resumes (1..255).
- `clk` in 1: word clock, same domain as the checker.
- `reset` in 1: synchronous, active-high.
- `aligned` in 1: checker lock status.
- `error_count` in 7: error bits in the current word, 0..64.
- `start` in 1: one-cycle pulse that clears statistics and begins a session.
- `stop` in 1: one-cycle pulse that ends the session; counters are retained.
- `snap_req` in 1: snapshot request, level, four-phase.
- `snap_ack` out 1: snapshot acknowledge.
- `state` out 2: IDLE=0, WAIT_LOCK=1, RUN=2, UNLOCKED=3.
- `total_bits` out 48: bits checked in RUN, +64 per cycle, saturating.
- `total_errors` out 32: sum of `error_count` in RUN, saturating.
- `lock_losses` out 8: RUN→UNLOCKED transitions, saturating at 255.
- `win_errors` out 24: error bits of the last completed window.
- `win_done` out 1: one-cycle pulse when `win_errors` updates.
- `max_win_errors` out 24: largest `win_errors` since `start`.
- `snap_bits` out 48, `snap_errors` out 32, `snap_losses` out 8: snapshot copies.

## Operation
- **Reset:** all outputs and internal counters go to 0, `state`=IDLE.
- **IDLE:**
  - `start` clears `total_*`, `lock_losses`, `win_errors`, `max_win_errors`, the window accumulator, the window counter and the settle counter, then moves to WAIT_LOCK.
  - `stop` is ignored.
- **WAIT_LOCK / UNLOCKED:**
  - The settle counter increments while `aligned`=1 and clears when `aligned`=0.
  - When the counter reaches SETTLE, the state moves to RUN and the settle counter clears.
  - No statistics accumulate in these states.
- **RUN, each cycle:**
  - `total_bits` += 64 and `total_errors` += `error_count`, each clamping at all-ones.
  - The window accumulator (24-bit, saturating) adds `error_count` and the window counter increments.
  - At window-counter terminal count 2^WINDOW_LOG2−1:
    - `win_errors` ← accumulator + `error_count` (saturating).
    - `win_done`=1.
    - `max_win_errors` updates if the new value is greater.
    - The accumulator and window counter clear.
- **Lock loss:** `aligned`=0 in RUN moves to UNLOCKED and increments `lock_losses`. The partial window is discarded: accumulator and window counter clear, no `win_done`. The cycle with `aligned`=0 is not counted.
- **`stop`:** in any non-IDLE state, moves to IDLE. If `stop` coincides with a RUN cycle, that cycle is not counted.
- **`start` outside IDLE:** restarts the session, with the same clearing as in IDLE, and goes to WAIT_LOCK.
- **`start` and `stop` together:** `stop` wins.
- **Snapshot:**
  - When `snap_req`=1 and `snap_ack`=0, the `snap_*` registers load the current register values of `total_bits`, `total_errors` and `lock_losses`, before this cycle's update.
  - `snap_ack` rises on the next cycle and stays high while `snap_req`=1.
  - `snap_ack` falls the cycle after `snap_req`=0.
  - `snap_*` hold their values until the next request.
  - Snapshots work in every state.

## Timing
- All outputs are registered, with one-cycle latency from the inputs.
- `win_done` and the updated `win_errors` appear in the same cycle.
- The first RUN cycle is the cycle after the SETTLEth consecutive `aligned`=1 sample.
- `snap_ack` goes high 1 cycle after `snap_req` rises and low 1 cycle after `snap_req` falls.
- Reset asserted mid-session or mid-handshake returns all state to reset values on the next edge.

## Configuration
- `BER_MONITOR_MAXWIN_EN`:
  - Defined: `max_win_errors` tracking is implemented as described in Operation.
  - Undefined: the comparator and register are omitted, and `max_win_errors` is tied to 0.

## Test plan
All scenarios use `WINDOW_LOG2`=4 and `SETTLE`=4.
- **Clean run:** `start`, `aligned`=1, `error_count`=0 for 40 cycles → `state` reaches 2 after 4 cycles; `win_done` pulses every 16 RUN cycles with `win_errors`=0; `total_bits`=64×(RUN cycles).
- **Error accumulation:** `error_count`=3 every RUN cycle → `win_errors`=48 at each `win_done`, `max_win_errors`=48, `total_errors`=3×(RUN cycles).
- **Lock loss mid-window:** drop `aligned` for 2 cycles after 10 RUN cycles → `state`=3, `lock_losses`=1, no `win_done`; return to RUN 4 cycles after `aligned` recovers; the next `win_done` comes 16 RUN cycles later.
- **Settle glitch:** in WAIT_LOCK, `aligned` pattern 1,1,1,0,1,1,1,1 → RUN is entered only after the final four 1s.
- **Snapshot:** raise `snap_req` during RUN → `snap_ack`=1 the next cycle; `snap_bits` equals `total_bits` from the cycle before the ack; `snap_*` stay unchanged while `total_bits` keeps growing; `snap_ack`=0 one cycle after `snap_req` falls.
- **Control corners:** `start` and `stop` in the same cycle during RUN → `state`=0 with counters retained; with `BER_MONITOR_MAXWIN_EN` undefined, `max_win_errors` stays 0.
